msi_multi_vector_engine: RTL
============================

// Module: msi_multi_vector_engine
// PURPOSE
//  Multi-vector MSI event engine for one PCIe function: latches per-vector interrupt requests into
//  Pending bits, applies per-vector masking, round-robin arbitrates and issues 32-bit MSI message data
//  (with optional Extended Message Data) to the TLP builder over a valid/ready handshake.
//  Sits between function event sources and the posted-write TLP generator; config fields come from the MSI capability.
// PARAMETERS
//  NUM_VECTORS       32  vectors implemented; power of 2, 1..32 (Multiple Message Capable = log2)
//  EXT_DATA_CAPABLE  1   1: Extended Message Data supported; 0: upper 16 msg bits always 0
//  PVM_CAPABLE       1   1: per-vector Mask/Pending implemented; 0: mask reads 0, writes ignored
// PORTS
//  clk               in   1    clock
//  rst               in   1    synchronous active-high reset
//  cfg_msi_enable    in   1    MSI Enable
//  cfg_mme           in   3    Multiple Message Enable (alloc = min(NUM_VECTORS, 2**cfg_mme))
//  cfg_ext_data_en   in   1    Extended Message Data Enable
//  cfg_msg_data      in   16   Message Data register
//  cfg_ext_msg_data  in   16   Extended Message Data register
//  mask_wr_en        in   1    write strobe for Mask Bits
//  mask_wr_data      in   NV   new Mask Bits value
//  mask_rdata        out  NV   current Mask Bits
//  pending_rdata     out  NV   current Pending Bits
//  irq_req           in   NV   per-vector event pulse, one bit per vector
//  msg_valid         out  1    message presented
//  msg_ready         in   1    TLP generator accepts message
//  msg_data          out  32   MSI data payload {ext[15:0], data[15:0]}
//  msg_vector        out  5    vector number being sent (post-aliasing)
// BEHAVIOUR
//  - Reset: mask=0, pending=0, msg_valid=0, msg_data=0, msg_vector=0, rr pointer=0, FSM=IDLE.
//  - irq_req[i] while cfg_msi_enable=1 sets pending[i]; ignored when 0. Pending persists across enable drop.
//  - Multiple requests on a pending vector coalesce into one message.
//  - Eligible = pending & ~mask (mask treated as 0 when PVM_CAPABLE=0), only when cfg_msi_enable=1.
//  - FSM IDLE: any eligible -> SEND next cycle; grant = first eligible at/after rr pointer, wrapping mod NV.
//    msg_valid rises 1 cycle after pending bit is visible (irq_req at cycle N -> msg_valid at N+2).
//  - SEND: msg_valid=1; msg_data/msg_vector captured at grant and held stable until msg_ready.
//    Handshake (valid&ready): clear pending[grant], rr pointer=grant+1 mod NV, return to IDLE (1 idle cycle min).
//  - No retraction: mask set, enable drop or cfg change during SEND do not drop or alter the message.
//  - irq_req on the granted vector in the handshake cycle: pending stays 1 (new event, sent later).
//  - Aliasing: alloc = min(NV, 2**cfg_mme); cfg_mme>5 treated as 5.
//    v = grant & (alloc-1); msg_data[15:0] = (cfg_msg_data & ~(alloc-1)) | v; msg_vector = v.
//  - msg_data[31:16] = cfg_ext_msg_data if EXT_DATA_CAPABLE && cfg_ext_data_en, else 16'h0000.
//  - mask_wr_en: mask <= mask_wr_data next cycle (PVM_CAPABLE=1); unmasking a pending vector makes it eligible.
//  - Mask affects only issue; pending still sets while masked.
//  - rst mid-SEND: msg_valid drops next cycle, all pending lost, no message completes.
// TESTING
//  - NV=4, mme=2, data=16'h4A00: irq_req=4'b0100 -> msg_valid at N+2, msg_data=32'h0000_4A02, vector=2.
//  - mask=4'b0010, irq_req[1] -> pending=4'b0010, no msg; write mask=0 -> msg with vector=1, pending clears.
//  - irq_req=4'b1111 together, ready=1 -> vectors sent 0,1,2,3 in order; next batch starts at rr pointer.
//  - mme=1 (alloc 2), data=16'h1235, grant 3 -> msg_data[15:0]=16'h1235 (bit0 = 3&1=1), vector=1.
//  - ext_en=1, ext=16'hBEEF, ready low 5 cycles -> msg_valid/data held 32'hBEEF_xxxx stable; clears on ready.
//  - msi_enable=0 + irq_req -> pending unchanged; rst during SEND -> msg_valid=0, pending=0 next cycle.

Source files
------------

// File: rtl/msi_multi_vector_engine.sv
// msi_multi_vector_engine
// Multi-vector MSI event engine for one PCIe function.
// - Per-vector interrupt requests are latched into Pending bits and can be masked per vector.
// - A round-robin arbiter picks the next eligible vector.
// - The engine presents one 32-bit MSI data word, with aliased vector bits and optional
//   extended data, to the posted-write TLP generator over a valid/ready handshake.
// Once presented, a message is never retracted or altered until it is accepted.

module msi_multi_vector_engine #(
    parameter int NUM_VECTORS      = 32,
    parameter bit EXT_DATA_CAPABLE = 1'b1,
    parameter bit PVM_CAPABLE      = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_msi_enable,
    input  logic [2:0]             cfg_mme,
    input  logic                   cfg_ext_data_en,
    input  logic [15:0]            cfg_msg_data,
    input  logic [15:0]            cfg_ext_msg_data,
    input  logic                   mask_wr_en,
    input  logic [NUM_VECTORS-1:0] mask_wr_data,
    output logic [NUM_VECTORS-1:0] mask_rdata,
    output logic [NUM_VECTORS-1:0] pending_rdata,
    input  logic [NUM_VECTORS-1:0] irq_req,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output logic [31:0]            msg_data,
    output logic [4:0]             msg_vector
);

    localparam int NV = NUM_VECTORS;
    localparam int PW = (NV > 1) ? $clog2(NV) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Round-robin pick: first set bit of elig at or after ptr, wrapping mod NV.
    // Scanning from the farthest offset down lets the nearest hit win last.
    function automatic logic [PW:0] rr_pick(input logic [NV-1:0] elig,
                                            input logic [PW-1:0] ptr);
        logic [PW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        for (int i = NV - 1; i >= 0; i--) begin
            idx = ptr + PW'(i);
            if (elig[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t          state_q;
    logic [NV-1:0]   pending_q;
    logic [NV-1:0]   pending_d;
    logic [NV-1:0]   mask_q;
    logic [NV-1:0]   mask_d;
    logic [PW-1:0]   rr_q;
    logic [PW-1:0]   grant_q;
    logic            msg_valid_q;
    logic [31:0]     msg_data_q;
    logic [4:0]      msg_vector_q;

    logic [NV-1:0]   eligible_s;
    logic [PW:0]     pick_s;
    logic            pick_found_s;
    logic [PW-1:0]   pick_idx_s;
    logic            handshake_s;
    logic [2:0]      mme_eff_s;
    logic [5:0]      alloc_s;
    logic [4:0]      alloc_mask_s;
    logic [4:0]      pick_vec5_s;
    logic [4:0]      alias_vec_s;
    logic [15:0]     data_lo_s;
    logic [15:0]     data_hi_s;

    // Eligibility and round-robin selection of the next vector to send.
    always_comb begin
        eligible_s = '0;
        if (cfg_msi_enable) begin
            eligible_s = pending_q & ~mask_q;
        end else begin
            eligible_s = '0;
        end
        pick_s       = rr_pick(eligible_s, rr_q);
        pick_found_s = pick_s[PW];
        pick_idx_s   = pick_s[PW-1:0];
        handshake_s  = (state_q == ST_SEND) && msg_valid_q && msg_ready;
    end

    // Vector aliasing and message data composition for the candidate grant.
    always_comb begin
        if (cfg_mme > 3'd5) begin
            mme_eff_s = 3'd5;
        end else begin
            mme_eff_s = cfg_mme;
        end
        alloc_s = 6'd1 << mme_eff_s;
        if (alloc_s > 6'(NV)) begin
            alloc_s = 6'(NV);
        end else begin
            alloc_s = alloc_s;
        end
        alloc_mask_s = 5'(alloc_s - 6'd1);
        pick_vec5_s  = 5'(pick_idx_s);
        alias_vec_s  = pick_vec5_s & alloc_mask_s;
        data_lo_s    = (cfg_msg_data & ~{11'h000, alloc_mask_s}) | {11'h000, alias_vec_s};
        if (EXT_DATA_CAPABLE && cfg_ext_data_en) begin
            data_hi_s = cfg_ext_msg_data;
        end else begin
            data_hi_s = 16'h0000;
        end
    end

    // Next pending: clear the accepted vector, then merge new enabled requests so a
    // request arriving in the handshake cycle survives as a fresh event.
    always_comb begin
        pending_d = pending_q;
        if (handshake_s) begin
            pending_d[grant_q] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (cfg_msi_enable) begin
            pending_d = pending_d | irq_req;
        end else begin
            pending_d = pending_d;
        end
    end

    // Next mask: writable only when per-vector masking is implemented.
    always_comb begin
        mask_d = mask_q;
        if (!PVM_CAPABLE) begin
            mask_d = '0;
        end else if (mask_wr_en) begin
            mask_d = mask_wr_data;
        end else begin
            mask_d = mask_q;
        end
    end

    // Pending and mask state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    // Issue FSM: captures grant and message at entry to SEND and holds them until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            msg_valid_q  <= 1'b0;
            msg_data_q   <= 32'h0000_0000;
            msg_vector_q <= 5'd0;
            grant_q      <= '0;
            rr_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        state_q      <= ST_SEND;
                        msg_valid_q  <= 1'b1;
                        msg_data_q   <= {data_hi_s, data_lo_s};
                        msg_vector_q <= alias_vec_s;
                        grant_q      <= pick_idx_s;
                    end else begin
                        state_q     <= ST_IDLE;
                        msg_valid_q <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (msg_ready) begin
                        state_q     <= ST_IDLE;
                        msg_valid_q <= 1'b0;
                        if (NV > 1) begin
                            rr_q <= grant_q + PW'(1);
                        end else begin
                            rr_q <= '0;
                        end
                    end else begin
                        state_q     <= ST_SEND;
                        msg_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    msg_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mask_rdata    = mask_q;
    assign pending_rdata = pending_q;
    assign msg_valid     = msg_valid_q;
    assign msg_data      = msg_data_q;
    assign msg_vector    = msg_vector_q;

endmodule
